// File: rtl/bitcell_pkg.sv
// Shared state encoding, access-direction constants and default geometry for the bitcell array.
package bitcell_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WR_EN    = 3'd1,
        ST_WR_REL   = 3'd2,
        ST_RD_SENSE = 3'd3,
        ST_RD_OUT   = 3'd4
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_ADDR_W = 4;

endpackage

// File: rtl/bitcell_word.sv
// One latch word: captures d on a clock edge while its word line (en) is high; async clear.
module bitcell_word #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Word-array sequencer: two-phase write (enable/release) and read (sense/present); optional PARITY_EN adds a parity bit per word.
// Latency: writes busy 2 cycles after accept; rdata_valid is high in the second cycle after accept.
// Backpressure: none; requests arriving while busy or out of range are dropped and flagged on err.
module bitcell_array_ctrl
    import bitcell_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic              err
);

`ifdef PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif

    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [DEPTH-1:0]    wl_en;
    logic [WORD_W-1:0]   word_d;
    logic [WORD_W-1:0]   word_q [DEPTH];
    logic [WORD_W-1:0]   sel_word;
    logic                in_range;
    logic                accept;
    logic                req_err;
    logic                par_err;

    assign in_range = ({1'b0, addr} < DEPTH_V);
    assign accept   = (state == ST_IDLE) && valid && in_range;
    assign req_err  = valid && ((state != ST_IDLE) || !in_range);
    assign busy     = (state != ST_IDLE);

`ifdef PARITY_EN
    // Even parity: the stored word including its parity bit always has an even number of ones.
    assign word_d  = {^wdata_q, wdata_q};
    assign par_err = (state == ST_RD_SENSE) && (^sel_word);
`else
    assign word_d  = wdata_q;
    assign par_err = 1'b0;
`endif

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:     if (accept) next_state = (rw == RW_WRITE) ? ST_WR_EN : ST_RD_SENSE;
            ST_WR_EN:    next_state = ST_WR_REL;
            ST_WR_REL:   next_state = ST_IDLE;
            ST_RD_SENSE: next_state = ST_RD_OUT;
            ST_RD_OUT:   next_state = ST_IDLE;
            default:     next_state = ST_IDLE;
        endcase
    end

    // One-hot word-line decode and read mux, both driven from the latched address.
    always_comb begin
        wl_en    = '0;
        sel_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wl_en[i] = (state == ST_WR_EN) && (addr_q == ADDR_W'(i));
            if (addr_q == ADDR_W'(i)) sel_word = word_q[i];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        bitcell_word #(.W(WORD_W)) u_word (
            .clk (clk),
            .rst (rst),
            .en  (wl_en[i]),
            .d   (word_d),
            .q   (word_q[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= next_state;
            rdata_valid <= (state == ST_RD_SENSE);
            err         <= req_err | par_err;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state == ST_RD_SENSE) rdata <= sel_word[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_bitcell_array_ctrl.sv
// Scoreboard bench: stimulus predicts read data / err pulses from a flat memory model; a negedge monitor checks them.
module tb_bitcell_array_ctrl;

    localparam int DEPTH = 12;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic       rw = 1'b0;
    logic [3:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       busy;
    logic       err;

    bitcell_array_ctrl #(.DATA_W(8), .DEPTH(DEPTH), .ADDR_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .valid       (valid),
        .rw          (rw),
        .addr        (addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         at;
        logic [7:0] data;
    } rd_exp_t;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] mem [DEPTH];
    rd_exp_t    rq [$];
    int         eq [$];
    int         acc = -100;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_err(input int t);
        if (eq.size() == 0 || eq[$] != t) eq.push_back(t);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        rq.delete();
        eq.delete();
        acc = -100;
    endfunction

    // Drive one request for one cycle in the current slot; predict the DUT's response.
    task automatic req(input logic r, input int a, input logic [7:0] d);
        int n;
        n = cyc;
        valid = 1'b1;
        rw    = r;
        addr  = a[3:0];
        wdata = d;
        if (n >= acc + 1 && n <= acc + 2) begin
            push_err(n + 1);
        end else if (a >= DEPTH) begin
            push_err(n + 1);
        end else begin
            acc = n;
            if (r) mem[a] = d;
            else   rq.push_back('{n + 2, mem[a]});
        end
        @(negedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            @(negedge clk); #1;
        end
    endtask

    // Monitor: every access completes at a cycle the model predicted, never elsewhere.
    always @(negedge clk) begin : mon
        rd_exp_t e;
        int      t;
        if (!rst) begin
            check("busy", busy, (cyc >= acc + 1 && cyc <= acc + 2));
            if (rdata_valid) begin
                if (rq.size() == 0) begin
                    check("unexpected rdata_valid", 1, 0);
                end else begin
                    e = rq.pop_front();
                    check("rdata_valid cycle", cyc, e.at);
                    check("rdata", rdata, e.data);
                end
            end else if (rq.size() > 0 && rq[0].at <= cyc) begin
                check("missing rdata_valid", 0, 1);
                void'(rq.pop_front());
            end
            if (err) begin
                if (eq.size() == 0) begin
                    check("unexpected err", 1, 0);
                end else begin
                    t = eq.pop_front();
                    check("err cycle", cyc, t);
                end
            end else if (eq.size() > 0 && eq[0] <= cyc) begin
                check("missing err", 0, 1);
                void'(eq.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset err", err, 0);
        check("reset rdata_valid", rdata_valid, 0);
        check("reset rdata", rdata, 8'h00);
        #1 rst = 1'b0;
        idle(1);

        // Unwritten word reads 0, then write/read round trip.
        req(0, 5, 8'h00);
        idle(2);
        req(1, 3, 8'hA5);
        idle(2);
        req(0, 3, 8'h00);
        idle(2);

        // Collision while in WR_EN: dropped, flagged, write still lands.
        req(1, 3, 8'h5A);
        req(0, 7, 8'h00);
        idle(2);
        req(0, 3, 8'h00);
        idle(2);

        // Out-of-range write is rejected and disturbs nothing.
        req(1, 14, 8'hFF);
        idle(1);
        for (int i = 0; i < DEPTH; i++) begin
            req(0, i, 8'h00);
            idle(2);
        end

        // Reset during WR_EN aborts the write and clears the array.
        req(1, 2, 8'h3C);
        rst = 1'b1;
        #1;
        check("rst mid-write busy", busy, 0);
        check("rst mid-write rdata_valid", rdata_valid, 0);
        model_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        idle(1);
        req(0, 2, 8'h00);
        idle(2);

        // Reset during RD_SENSE suppresses the pending rdata_valid.
        req(1, 4, 8'h77);
        idle(2);
        req(0, 4, 8'h00);
        rst = 1'b1;
        #1;
        check("rst mid-read rdata_valid", rdata_valid, 0);
        model_reset();
        @(negedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Parity: clean read never flags; corrupted word flags only with the feature built in.
        req(1, 1, 8'h0F);
        idle(2);
        req(0, 1, 8'h00);
        idle(2);
`ifdef PARITY_EN
        force dut.g_word[1].u_word.q[0] = 1'b0;
        mem[1] = 8'h0E;
        push_err(cyc + 2);
        req(0, 1, 8'h00);
        idle(2);
        release dut.g_word[1].u_word.q[0];
        req(1, 1, 8'h0F);
        idle(2);
`endif

        // Random traffic, including back-to-back requests that collide.
        for (int k = 0; k < 400; k++) begin
            req(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end

        idle(5);
        check("read expectations drained", rq.size(), 0);
        check("err expectations drained", eq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
